// File: rtl/qrcode_result_packer.sv
// qrcode_result_packer: captures decoded QR text runs into two ping-pong
// record buffers and streams each record as {loc_y, loc_x, len, payload}.
module qrcode_result_packer #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       dec_valid,
    input  logic [7:0] dec_text,
    input  logic [5:0] dec_loc_y,
    input  logic [5:0] dec_loc_x,
    input  logic       dec_finish,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       done,
    output logic       overflow
);
    typedef enum logic [2:0] {
        RD_IDLE,
        RD_HDR_Y,
        RD_HDR_X,
        RD_HDR_LEN,
        RD_PAYLOAD
    } rd_state_e;

    localparam int               IDX_W     = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [7:0]       mem_q  [2][MAX_LEN];
    logic [LEN_W-1:0] len_q  [2];
    logic [5:0]       locy_q [2];
    logic [5:0]       locx_q [2];
    logic [1:0]       full_q, full_d;
    logic             wsel_q, rsel_q;
    logic             in_run_q, drop_q;
    logic             overflow_q, overflow_d;
    logic             finish_q, finish_d;
    rd_state_e        state_q, state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

    logic             run_start, run_cont, run_end;
    logic             start_ok, has_room, wr_en, ovf_evt;
    logic [IDX_W-1:0] wr_idx;
    logic [LEN_W-1:0] last_idx;
    logic             rd_done;

    // capture-side event decode for the current cycle
    always_comb begin
        run_start = dec_valid & ~in_run_q;
        run_cont  = dec_valid & in_run_q & ~drop_q;
        run_end   = ~dec_valid & in_run_q & ~drop_q;
        start_ok  = run_start & ~full_q[wsel_q];
        has_room  = len_q[wsel_q] < MAX_LEN_L;
        wr_en     = start_ok | (run_cont & has_room);
        wr_idx    = start_ok ? '0 : len_q[wsel_q][IDX_W-1:0];
        ovf_evt   = (run_start & full_q[wsel_q]) | (run_cont & ~has_room);
    end

    // payload storage, contents only meaningful while the buffer is full
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wsel_q][wr_idx] <= dec_text;
        end
    end

    // capture side: run tracking, header latch, length count, write select
    always_ff @(posedge clk) begin
        if (srst) begin
            in_run_q  <= 1'b0;
            drop_q    <= 1'b0;
            wsel_q    <= 1'b0;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
            locy_q[0] <= '0;
            locy_q[1] <= '0;
            locx_q[0] <= '0;
            locx_q[1] <= '0;
        end else begin
            in_run_q <= dec_valid;
            if (run_start) begin
                drop_q <= full_q[wsel_q];
            end
            if (start_ok) begin
                locy_q[wsel_q] <= dec_loc_y;
                locx_q[wsel_q] <= dec_loc_x;
                len_q[wsel_q]  <= LEN_W'(1);
            end else if (run_cont && has_room) begin
                len_q[wsel_q] <= len_q[wsel_q] + LEN_W'(1);
            end
            if (run_end) begin
                wsel_q <= ~wsel_q;
            end
        end
    end

    // read FSM next state and byte mux; out_valid depends on state only
    always_comb begin
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        rd_done   = 1'b0;
        last_idx  = len_q[rsel_q] - LEN_W'(1);
        unique case (state_q)
            RD_IDLE: begin
                if (full_q[rsel_q]) begin
                    state_d = RD_HDR_Y;
                end
            end
            RD_HDR_Y: begin
                out_valid = 1'b1;
                out_data  = {2'b00, locy_q[rsel_q]};
                if (out_ready) begin
                    state_d = RD_HDR_X;
                end
            end
            RD_HDR_X: begin
                out_valid = 1'b1;
                out_data  = {2'b00, locx_q[rsel_q]};
                if (out_ready) begin
                    state_d = RD_HDR_LEN;
                end
            end
            RD_HDR_LEN: begin
                out_valid = 1'b1;
                out_data  = 8'(len_q[rsel_q]);
                if (out_ready) begin
                    state_d  = RD_PAYLOAD;
                    rd_idx_d = '0;
                end
            end
            RD_PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = mem_q[rsel_q][rd_idx_q];
                out_last  = (LEN_W'(rd_idx_q) == last_idx);
                if (out_ready) begin
                    if (out_last) begin
                        state_d = RD_IDLE;
                        rd_done = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // buffer ownership, sticky overflow and finish tracking
    always_comb begin
        full_d = full_q;
        if (rd_done) begin
            full_d[rsel_q] = 1'b0;
        end
        if (run_end) begin
            full_d[wsel_q] = 1'b1;
        end
        overflow_d = overflow_q | ovf_evt;
        done = finish_q & ~in_run_q & ~dec_valid
             & (full_q == 2'b00) & (state_q == RD_IDLE);
        finish_d = done ? dec_finish : (finish_q | dec_finish);
    end

    // read-side and status state registers
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= RD_IDLE;
            rd_idx_q   <= '0;
            rsel_q     <= 1'b0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            finish_q   <= finish_d;
            if (rd_done) begin
                rsel_q <= ~rsel_q;
            end
        end
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_qrcode_result_packer.sv
// tb_qrcode_result_packer: directed and randomized runs checked against a
// record-level reference model of the ping-pong packer.
module tb_qrcode_result_packer;
    localparam int MAX_LEN = 32;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       dec_valid = 1'b0;
    logic [7:0] dec_text = 8'h00;
    logic [5:0] dec_loc_y = 6'd0;
    logic [5:0] dec_loc_x = 6'd0;
    logic       dec_finish = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       done;
    logic       overflow;

    qrcode_result_packer #(.MAX_LEN(MAX_LEN), .LEN_W(6)) dut (
        .clk       (clk),
        .srst      (srst),
        .dec_valid (dec_valid),
        .dec_text  (dec_text),
        .dec_loc_y (dec_loc_y),
        .dec_loc_x (dec_loc_x),
        .dec_finish(dec_finish),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int rdy_mode = 1;

    logic [8:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] txt[$];
    logic [7:0] m_buf[$];
    logic [5:0] m_y, m_x;
    int  pending = 0;
    bit  m_in_run = 0, m_drop = 0, m_ovf = 0, m_fin = 0;
    bit  prev_stall = 0;
    int  last_hs_cyc = -1, done_cyc = -1, done_cnt = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_buf.delete();
        pending  = 0;
        m_in_run = 0;
        m_drop   = 0;
        m_ovf    = 0;
        m_fin    = 0;
        prev_stall = 0;
    endtask

    task automatic tick();
        bit hs, exp_done;
        logic [8:0] e;
        case (rdy_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            2: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        exp_done = m_fin && !dec_valid && !m_in_run && pending == 0;
        if (!srst) begin
            chk("done", done, exp_done);
            chk("overflow", overflow, m_ovf);
            if (prev_stall) chk("valid_held", out_valid, 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", out_valid, 0);
                end else begin
                    e = exp_q[0];
                    chk("data", out_data, e[7:0]);
                    chk("last", out_last, e[8]);
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        hs = out_valid && out_ready;
        prev_stall = out_valid && !out_ready && !srst;
        if (srst) begin
            model_reset();
        end else begin
            if (dec_valid && !m_in_run) begin
                m_drop = (pending == 2);
                if (m_drop) begin
                    m_ovf = 1;
                end else begin
                    m_buf.delete();
                    m_buf.push_back(dec_text);
                    m_y = dec_loc_y;
                    m_x = dec_loc_x;
                end
            end else if (dec_valid && !m_drop) begin
                if (m_buf.size() < MAX_LEN) m_buf.push_back(dec_text);
                else m_ovf = 1;
            end else if (!dec_valid && m_in_run && !m_drop) begin
                exp_q.push_back({1'b0, 2'b00, m_y});
                exp_q.push_back({1'b0, 2'b00, m_x});
                exp_q.push_back({1'b0, 8'(m_buf.size())});
                for (int i = 0; i < m_buf.size(); i++)
                    exp_q.push_back({(i == m_buf.size() - 1), m_buf[i]});
                pending++;
            end
            if (hs && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got_q.push_back(out_data);
                if (e[8]) begin
                    pending--;
                    last_hs_cyc = cyc;
                end
            end
            if (exp_done) m_fin = 0;
            if (dec_finish) m_fin = 1;
            m_in_run = dec_valid;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n);
        dec_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fill_rand(int n);
        txt.delete();
        for (int i = 0; i < n; i++) txt.push_back(8'($urandom));
    endtask

    task automatic send(logic [5:0] y, logic [5:0] x);
        for (int i = 0; i < txt.size(); i++) begin
            dec_valid = 1'b1;
            dec_text  = txt[i];
            dec_loc_y = y;
            dec_loc_x = x;
            tick();
        end
        dec_valid = 1'b0;
        dec_text  = 8'($urandom);
    endtask

    task automatic drain(int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            tick();
            k++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
    endtask

    logic [7:0] exp1 [5] = '{8'h03, 8'h0A, 8'h02, 8'h48, 8'h49};

    initial begin
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);

        rdy_mode = 1;
        got_q.delete();
        txt = '{8'h48, 8'h49};
        send(6'd3, 6'd10);
        idle(1);
        drain(50);
        chk("t1_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < got_q.size()) chk("t1_byte", got_q[i], exp1[i]);

        rdy_mode = 2;
        got_q.delete();
        txt = '{8'h48, 8'h49};
        send(6'd3, 6'd10);
        idle(1);
        drain(50);
        chk("t2_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < got_q.size()) chk("t2_byte", got_q[i], exp1[i]);

        rdy_mode = 0;
        got_q.delete();
        fill_rand(5);
        send(6'd1, 6'd2);
        idle(1);
        fill_rand(7);
        send(6'd4, 6'd5);
        idle(2);
        rdy_mode = 1;
        drain(100);
        chk("t3_count", got_q.size(), 18);
        chk("t3_ovf", overflow, 0);

        rdy_mode = 0;
        got_q.delete();
        fill_rand(4);
        send(6'd7, 6'd8);
        idle(1);
        fill_rand(6);
        send(6'd9, 6'd11);
        idle(1);
        fill_rand(3);
        send(6'd12, 6'd13);
        idle(2);
        chk("t4_ovf", overflow, 1);
        rdy_mode = 1;
        drain(100);
        chk("t4_count", got_q.size(), 16);
        if (got_q.size() == 16) begin
            chk("t4_len0", got_q[2], 4);
            chk("t4_len1", got_q[9], 6);
        end

        do_reset();
        rdy_mode = 3;
        got_q.delete();
        fill_rand(MAX_LEN + 3);
        send(6'd63, 6'd62);
        idle(1);
        chk("t5_ovf", overflow, 1);
        drain(400);
        chk("t5_count", got_q.size(), MAX_LEN + 3);
        if (got_q.size() > 2) chk("t5_len", got_q[2], 8'h20);

        for (int r = 0; r < 10; r++) begin
            fill_rand($urandom_range(1, 40));
            send(6'($urandom), 6'($urandom));
            idle($urandom_range(1, 4));
        end
        drain(2000);

        do_reset();
        rdy_mode = 1;
        done_cnt = 0;
        fill_rand(3);
        send(6'd20, 6'd21);
        idle(1);
        dec_finish = 1'b1;
        tick();
        dec_finish = 1'b0;
        drain(50);
        idle(4);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_done_cyc", done_cyc, last_hs_cyc + 1);

        rdy_mode = 1;
        got_q.delete();
        fill_rand(10);
        send(6'd30, 6'd31);
        begin
            int k = 0;
            while (got_q.size() < 5 && k < 50) begin
                idle(1);
                k++;
            end
        end
        chk("t7_mid_payload", got_q.size(), 5);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("t7_srst_valid", out_valid, 0);
        idle(5);
        chk("t7_idle_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
